// File: rtl/aes_pkg.sv
// Shared AES constants and the byte streamer state encoding.
// AES_KAT_CIPHER is also used by the board LED known-answer check.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;

  localparam logic [AES_BLOCK_W-1:0] AES_KAT_CIPHER =
    128'h4b286e22c5d2113d01227cc2cdf88f39;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } stream_state_e;
endpackage

// File: rtl/cipher_byte_streamer.sv
// Captures a cipher block and streams it out one byte per valid/ready transfer.
// Optional known-answer flag (kat_match) is built when CIPHER_STREAM_KAT_EN is defined.
module cipher_byte_streamer
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef CIPHER_STREAM_KAT_EN
  output logic                              kat_match,
`endif
  input  logic [AES_BYTE_W*NUM_BYTES-1:0]   cipher_text,
  input  logic                              cipher_valid,
  output logic [AES_BYTE_W-1:0]             byte_out,
  output logic                              byte_valid,
  input  logic                              byte_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              overrun
);
  localparam int W     = AES_BYTE_W * NUM_BYTES;
  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BYTES - 1);

  stream_state_e           r_state;
  logic [W-1:0]            r_sr;
  logic [CNT_W-1:0]        r_cnt;

  logic [W-1:0]            w_shifted;
  logic [AES_BYTE_W-1:0]   w_first_byte;
  logic [AES_BYTE_W-1:0]   w_next_byte;
  logic                    w_xfer;

  // r_sr always holds the current byte in its output slot, so the next byte
  // comes from the slot of the shifted value.
  always_comb begin
    if (MSB_FIRST) begin
      w_shifted    = r_sr << AES_BYTE_W;
      w_first_byte = cipher_text[W-1 -: AES_BYTE_W];
      w_next_byte  = w_shifted[W-1 -: AES_BYTE_W];
    end else begin
      w_shifted    = r_sr >> AES_BYTE_W;
      w_first_byte = cipher_text[AES_BYTE_W-1:0];
      w_next_byte  = w_shifted[AES_BYTE_W-1:0];
    end
  end

  assign w_xfer = byte_valid && byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
`ifdef CIPHER_STREAM_KAT_EN
      kat_match  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (cipher_valid) begin
            r_sr       <= cipher_text;
            r_cnt      <= '0;
            byte_out   <= w_first_byte;
            byte_valid <= 1'b1;
            busy       <= 1'b1;
            r_state    <= SEND;
`ifdef CIPHER_STREAM_KAT_EN
            kat_match  <= (cipher_text == W'(AES_KAT_CIPHER));
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        SEND: begin
          if (cipher_valid) overrun <= 1'b1;
          if (w_xfer) begin
            if (r_cnt == LAST) begin
              byte_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_cnt    <= r_cnt + 1'b1;
              r_sr     <= w_shifted;
              byte_out <= w_next_byte;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cipher_byte_streamer.sv
// Directed bench: MSB/LSB ordering, backpressure, overrun, DONE-cycle capture, mid-stream reset.
module tb_cipher_byte_streamer;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] cipher_text;
  logic         cipher_valid;
  logic         byte_ready;
  logic [7:0]   byte_out, byte_out_l;
  logic         byte_valid, busy, done, overrun;
  logic         byte_valid_l, busy_l, done_l, overrun_l;
`ifdef CIPHER_STREAM_KAT_EN
  logic         kat_match, kat_match_l;
`endif

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [127:0] C = 128'h4b286e22c5d2113d01227cc2cdf88f39;
  localparam logic [127:0] D = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  cipher_byte_streamer #(.NUM_BYTES(16), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
`ifdef CIPHER_STREAM_KAT_EN
    .kat_match(kat_match),
`endif
    .cipher_text(cipher_text), .cipher_valid(cipher_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  cipher_byte_streamer #(.NUM_BYTES(16), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst),
`ifdef CIPHER_STREAM_KAT_EN
    .kat_match(kat_match_l),
`endif
    .cipher_text(cipher_text), .cipher_valid(cipher_valid),
    .byte_out(byte_out_l), .byte_valid(byte_valid_l), .byte_ready(byte_ready),
    .busy(busy_l), .done(done_l), .overrun(overrun_l)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] msb_byte(input logic [127:0] c, input int i);
    return c[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] lsb_byte(input logic [127:0] c, input int i);
    return c[8*i +: 8];
  endfunction

  task automatic capture(input logic [127:0] c);
    cipher_text  = c;
    cipher_valid = 1'b1;
    step();
    cipher_valid = 1'b0;
    cipher_text  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Byte-per-cycle streaming with byte_ready high, checking indexes [from,to).
  task automatic stream(input string tag, input logic [127:0] c, input int from, input int to);
    byte_ready = 1'b1;
    for (int i = from; i < to; i++) begin
      check({tag, "_valid"}, 128'(byte_valid), 128'(1'b1));
      check({tag, "_byte"},  128'(byte_out),   128'(msb_byte(c, i)));
      step();
    end
  endtask

  initial begin
    rst = 1'b1; cipher_text = '0; cipher_valid = 1'b0; byte_ready = 1'b0;
    #2;
    check("rst_byte_out", 128'(byte_out),   128'(0));
    check("rst_valid",    128'(byte_valid), 128'(0));
    check("rst_busy",     128'(busy),       128'(0));
    check("rst_done",     128'(done),       128'(0));
    check("rst_overrun",  128'(overrun),    128'(0));
    step();
    rst = 1'b0;
    step();

    // Test 1: straight stream, both byte orders in parallel
    capture(C);
    byte_ready = 1'b1;
    check("t1_busy", 128'(busy), 128'(1));
`ifdef CIPHER_STREAM_KAT_EN
    check("t1_kat", 128'(kat_match), 128'(1));
`endif
    for (int i = 0; i < 16; i++) begin
      check("t1_valid", 128'(byte_valid), 128'(1));
      check("t1_byte",  128'(byte_out),   128'(msb_byte(C, i)));
      check("t1_lsb",   128'(byte_out_l), 128'(lsb_byte(C, i)));
      check("t1_nodone", 128'(done), 128'(0));
      step();
    end
    check("t1_done",   128'(done),       128'(1));
    check("t1_vld0",   128'(byte_valid), 128'(0));
    check("t1_busy0",  128'(busy),       128'(0));
    check("t1_ldone",  128'(done_l),     128'(1));
    step();
    check("t1_done_pulse", 128'(done), 128'(0));

    // Test 2: byte_ready toggling; output must hold while ready is low
    capture(C);
    begin
      int k = 0;
      for (int cyc = 0; cyc < 40 && k < 16; cyc++) begin
        logic rdy;
        rdy = cyc[0];
        check("t2_valid", 128'(byte_valid), 128'(1));
        check("t2_byte",  128'(byte_out),   128'(msb_byte(C, k)));
        byte_ready = rdy;
        step();
        if (rdy) k++;
      end
      check("t2_count", 128'(k), 128'(16));
    end
    check("t2_done", 128'(done), 128'(1));
    byte_ready = 1'b0;
    step();

    // Test 3: second block arriving mid-stream is dropped and flagged
    capture(C);
    stream("t3a", C, 0, 5);
    cipher_valid = 1'b1;
    cipher_text  = '0;
    check("t3_byte5", 128'(byte_out), 128'(msb_byte(C, 5)));
    step();
    cipher_valid = 1'b0;
    check("t3_overrun", 128'(overrun), 128'(1));
    stream("t3b", C, 6, 16);
    check("t3_done", 128'(done), 128'(1));
    step();
    check("t3_no2nd",   128'(byte_valid), 128'(0));
    check("t3_busy",    128'(busy),       128'(0));
    check("t3_sticky",  128'(overrun),    128'(1));

    // Test 4: capture in the DONE cycle starts the next block immediately
    do_reset();
    capture(C);
    stream("t4a", C, 0, 16);
    check("t4_done", 128'(done), 128'(1));
    capture(D);
    check("t4_done0",  128'(done),       128'(0));
    check("t4_busy",   128'(busy),       128'(1));
    check("t4_first",  128'(byte_out),   128'(8'h00));
`ifdef CIPHER_STREAM_KAT_EN
    check("t4_kat0", 128'(kat_match), 128'(0));
`endif
    stream("t4b", D, 0, 16);
    check("t4_done2",   128'(done),    128'(1));
    check("t4_overrun", 128'(overrun), 128'(0));
    step();

    // Test 5: asynchronous reset mid-stream, then a clean restart
    capture(C);
    stream("t5a", C, 0, 8);
    check("t5_byte8", 128'(byte_out), 128'(msb_byte(C, 8)));
    #2 rst = 1'b1;
    #1;
    check("t5_valid", 128'(byte_valid), 128'(0));
    check("t5_busy",  128'(busy),       128'(0));
    check("t5_done",  128'(done),       128'(0));
    check("t5_bout",  128'(byte_out),   128'(0));
    step();
    rst = 1'b0;
    step();
    check("t5_idle", 128'(byte_valid), 128'(0));
    capture(C);
    stream("t5b", C, 0, 16);
    check("t5_done2", 128'(done), 128'(1));
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
